bcd_lap_timer: RTL
==================

BCD_LAP_TIMER -- requirements
Module: bcd_lap_timer

Interface
REQ-001 Parameter TICK_DIV, default 500000: clk cycles per least-significant-digit step (>=2).
REQ-002 Parameter FRAC_DIGITS, default 2: sub-second BCD digits, legal 1..3.
REQ-003 Parameter LAP_DEPTH, default 8: lap FIFO entries, power of 2.
REQ-004 Derived TW = 16 + 4*FRAC_DIGITS; time word = {min_h, min_l, sec_h, sec_l, frac...}, 4-bit BCD each, MSB first.
REQ-005 There SHALL be one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start / stop / clear / load / lap  in  1 each  single-cycle commands.
REQ-009 mode  in  1  0 = count up, 1 = count down.
REQ-010 preset_time  in  TW  value taken by load; alarm_time  in  TW  alarm compare value.
REQ-011 lap_rd  in  1  pop FIFO head.
REQ-012 time_now  out  TW  current time; tick  out  1  one-cycle strobe, high with each new time_now.
REQ-013 running  out  1  state is RUN; done  out  1  countdown reached zero.
REQ-014 alarm / overflow  out  1 each  sticky flags.
REQ-015 lap_time  out  TW  FIFO head (first-word-fall-through); lap_empty, lap_full  out  1; lap_count  out  clog2(LAP_DEPTH)+1.

Function
REQ-016 States IDLE, RUN, PAUSE, DONE; command priority clear > load > stop > start.
REQ-017 clear (any state): -> IDLE, time_now, prescaler, FIFO, alarm, overflow, done all zero.
REQ-018 load honoured only in IDLE/PAUSE/DONE: time_now <= preset_time, -> IDLE; ignored in RUN.
REQ-019 Load clamps each illegal digit to its maximum (sec_h 5, others 9).
REQ-020 start: IDLE/PAUSE -> RUN; ignored in RUN and DONE; start from IDLE zeroes prescaler.
REQ-021 stop: RUN -> PAUSE; prescaler and time_now held; resume continues the partial tick.
REQ-022 mode sampled only outside RUN; changes during RUN ignored until next stop.
REQ-023 In RUN prescaler counts 0..TICK_DIV-1; on the edge at TICK_DIV-1 it returns to 0, time_now steps by one LSD, tick = 1 for the following cycle.
REQ-024 Digit moduli: frac 10, sec_l 10, sec_h 6, min_l 10, min_h 10; carry/borrow ripples within one cycle.
REQ-025 Up: 99:59.(9..9) + 1 -> all zero, overflow set, counting continues.
REQ-026 Down: step reaching all zero -> DONE, done = 1, prescaler stops; start in down mode at zero -> DONE next cycle.
REQ-027 alarm sets the cycle after time_now == alarm_time in RUN; cleared only by clear/rst.
REQ-028 lap in RUN/PAUSE pushes current time_now (pre-step value on a step edge); ignored in IDLE/DONE.
REQ-029 Push when full is dropped, FIFO unchanged; lap_rd when empty ignored.
REQ-030 Simultaneous push and pop: both performed, lap_count unchanged, legal even when full.

Reset
REQ-031 rst asserted: immediately state IDLE, all outputs and FIFO pointers 0, lap_empty = 1.
REQ-032 rst during RUN discards the partial tick; first edge after deassert is a normal IDLE cycle.

Structure
REQ-033 Shared package bcd_timer_pkg: state encodings, digit moduli, TW derivation.
REQ-034 Sub-module bcd_digit_cnt: one BCD digit, parameter modulus, up/down, enable in, carry/borrow out; one instance per digit.

Verification (TICK_DIV=4, FRAC_DIGITS=2, LAP_DEPTH=4)
REQ-035 start, 400 cycles -> time_now 00:01.00, tick every 4 cycles, running = 1.
REQ-036 load 00:59.99, start -> 01:00.00 after 4 cycles; load 99:59.99, start -> 00:00.00, overflow = 1.
REQ-037 start, stop at cycle 6, wait 20, start -> next step 2 cycles after restart (partial tick kept).
REQ-038 mode=1, load 00:00.03, start -> 00:00.00 at cycle 12, done = 1, DONE, no further tick.
REQ-039 5 laps at distinct times -> lap_full after 4th, 5th dropped, 4 reads return in order, then lap_empty.
REQ-040 rst pulse between edges mid-RUN -> all outputs zero immediately, IDLE after release.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and derivations for the BCD lap timer.
// Digit moduli, state encoding and time-word width.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned MOD_DEC   = 10;
    localparam int unsigned MOD_SEC_H = 6;

    function automatic int unsigned time_width(input int unsigned frac_digits);
        return 16 + 4 * frac_digits;
    endfunction

    // Digit index 0 is the least significant fraction digit.
    function automatic int unsigned digit_mod(input int unsigned idx,
                                              input int unsigned frac_digits);
        return (idx == frac_digits + 1) ? MOD_SEC_H : MOD_DEC;
    endfunction

endpackage

// File: rtl/bcd_lap_timer_digit.sv
// One BCD digit with load clamp, up/down stepping and ripple carry/borrow.
// carry is combinational so a full ripple settles within one cycle.
module bcd_digit_cnt
    import bcd_timer_pkg::*;
#(
    parameter int unsigned MOD = MOD_DEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       down,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX = 4'(MOD - 1);

    logic at_edge;

    assign at_edge = down ? (q == 4'd0) : (q == MAX);
    assign carry   = en && at_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (at_edge)
                q <= down ? MAX : 4'd0;
            else
                q <= down ? q - 4'd1 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_lap_timer.sv
// Stopwatch / countdown timer in BCD with sticky alarm, overflow and a lap FIFO.
// Commands are single-cycle; priority clear > load > stop > start.
module bcd_lap_timer
    import bcd_timer_pkg::*;
#(
    parameter  int unsigned TICK_DIV    = 500000,
    parameter  int unsigned FRAC_DIGITS = 2,
    parameter  int unsigned LAP_DEPTH   = 8,
    localparam int unsigned TW          = time_width(FRAC_DIGITS),
    localparam int unsigned CW          = $clog2(LAP_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          load,
    input  logic          lap,
    input  logic          mode,
    input  logic [TW-1:0] preset_time,
    input  logic [TW-1:0] alarm_time,
    input  logic          lap_rd,
    output logic [TW-1:0] time_now,
    output logic          tick,
    output logic          running,
    output logic          done,
    output logic          alarm,
    output logic          overflow,
    output logic [TW-1:0] lap_time,
    output logic          lap_empty,
    output logic          lap_full,
    output logic [CW-1:0] lap_count
);

    localparam int unsigned ND = 4 + FRAC_DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = CW - 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t state, state_nxt;
    logic [PW-1:0] presc;
    logic dir;
    logic step, do_load, do_start;
    logic [ND:0] en;

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_start  = 1'b0;
        step      = 1'b0;
        if (clear) begin
            state_nxt = S_IDLE;
        end else if (load && state != S_RUN) begin
            do_load   = 1'b1;
            state_nxt = S_IDLE;
        end else if (stop && state == S_RUN) begin
            state_nxt = S_PAUSE;
        end else if (start && (state == S_IDLE || state == S_PAUSE)) begin
            do_start  = 1'b1;
            state_nxt = (mode && time_now == '0) ? S_DONE : S_RUN;
        end else if (state == S_RUN && presc == PRESC_MAX) begin
            step = 1'b1;
            // A down step from one LSD lands on zero.
            if (dir && time_now == TW'(1))
                state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            dir      <= 1'b0;
            tick     <= 1'b0;
            alarm    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            tick  <= step;
            if (state != S_RUN)
                dir <= mode;
            if (clear) begin
                presc    <= '0;
                alarm    <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if ((do_start && state == S_IDLE) || step)
                    presc <= '0;
                else if (state == S_RUN && state_nxt == S_RUN)
                    presc <= presc + PW'(1);
                if (state == S_RUN && time_now == alarm_time)
                    alarm <= 1'b1;
                if (step && !dir && en[ND])
                    overflow <= 1'b1;
            end
        end
    end

    assign en[0] = step;

    for (genvar i = 0; i < ND; i++) begin : g_digit
        logic [3:0] q;
        bcd_digit_cnt #(
            .MOD(digit_mod(i, FRAC_DIGITS))
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .clr     (clear),
            .load    (do_load),
            .load_val(preset_time[4*i +: 4]),
            .en      (en[i]),
            .down    (dir),
            .q       (q),
            .carry   (en[i+1])
        );
        assign time_now[4*i +: 4] = q;
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

    logic [TW-1:0] mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic push, pop;

    assign lap_empty = (cnt == '0);
    assign lap_full  = (cnt == CW'(LAP_DEPTH));
    assign lap_count = cnt;
    assign lap_time  = lap_empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees the slot the push needs.
    assign pop  = lap_rd && !lap_empty && !clear;
    assign push = lap && (state == S_RUN || state == S_PAUSE) && !clear
                  && (!lap_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= time_now;
    end

endmodule
